ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction-fetch stage of the RV64 in-order pipeline, directly upstream of the decode stage.
- Owns the fetch PC and issues word fetches over a req/gnt/rvalid instruction-memory interface.
- Buffers returned instructions in a small in-order queue and presents one instruction per cycle to decode.
- Honours decode hazard stalls (hold) and pipeline flushes (redirect plus drop of in-flight responses).

Parameters:
- RESET_PC, 64'h8000_0000, first fetch address after reset.
- DEPTH, 2, instruction queue entries; also the cap on in-flight plus buffered fetches; power of 2, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_nop  in  1  redirect fetch this cycle (branch/jump resolved).
- redirect_pc  in  64  new PC when flush_nop=1; bits [1:0] ignored (treated as 0).
- hazard_nop  in  1  decode stalls this cycle; current instruction must be re-presented.
- imem_req  out  1  fetch request valid.
- imem_addr  out  64  fetch address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant.
- imem_rdata  in  32  response instruction.
- ifu_instr  out  32  head instruction.
- ifu_pc  out  64  PC of head instruction.
- ifu_snxt_pc  out  64  static next PC = ifu_pc + 4.
- ifu_valid  out  1  head entry valid.
- instr_valid  out  1  decode latch enable = ifu_valid & ~hazard_nop & ~flush_nop.

Behaviour:
- Reset values: fetch_pc = RESET_PC; deq_pc = RESET_PC; queue empty; outstanding = 0; drop_cnt = 0.
- Reset output values: imem_req=0, imem_addr=RESET_PC, ifu_valid=0, instr_valid=0, ifu_instr=0, ifu_pc=RESET_PC, ifu_snxt_pc=RESET_PC+4.
- Reset mid-operation clears all state immediately; responses to pre-reset fetches are unsupported (memory is reset too).
- Request rule: imem_req = ~flush_nop & (outstanding + count < DEPTH) & (drop_cnt == 0 or issuing is still within the cap); imem_addr = fetch_pc.
- Once raised, imem_req and imem_addr stay stable until granted, unless a flush intervenes.
- Grant: imem_req & imem_gnt advances fetch_pc by 4 and increments outstanding.
- Response with drop_cnt > 0: data discarded; drop_cnt and outstanding decrement.
- Response with drop_cnt = 0: imem_rdata pushed to the queue tail; outstanding decrements.
- Grant and response in the same cycle: the two outstanding updates net to zero.
- The queue never overflows; the request cap guarantees space for every in-flight response.
- Head output: ifu_valid = (count > 0); ifu_instr = queue head; ifu_pc = deq_pc.
- Load-to-use latency: response accepted at cycle N gives ifu_valid=1 at cycle N+1. There is no combinational bypass.
- Consume: when instr_valid=1, the head pops and deq_pc += 4.
- Same-cycle pop and push on a full queue is legal.
- Hazard: hazard_nop=1 means no pop, and ifu_instr/ifu_pc are held; fetching continues until the cap is reached.
- Flush (priority over hazard_nop), applied at the clock edge:
  - fetch_pc and deq_pc take {redirect_pc[63:2], 2'b00}.
  - Queue is cleared.
  - drop_cnt takes outstanding minus imem_rvalid; the response arriving in the flush cycle is itself discarded.
  - imem_req is forced to 0 during the flush cycle, so no stale grant occurs.
- Back-to-back flushes: each flush recomputes drop_cnt from the current outstanding count.
- PC arithmetic is modulo 2^64; wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 is legal.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- When defined, adds outputs perf_fetch_cnt[63:0] and perf_stall_cnt[63:0], both reset to 0.
  - perf_fetch_cnt increments on each instr_valid=1 cycle.
  - perf_stall_cnt increments on each cycle with ifu_valid=0 & ~flush_nop.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then imem_gnt=1 and rvalid 1 cycle after each grant with rdata=32'h0000_0013 -> ifu_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; ifu_snxt_pc = ifu_pc+4; first ifu_valid 2 cycles after the first grant.
- imem_gnt=0 for 5 cycles -> imem_req=1 and imem_addr=0x8000_0000 held stable; ifu_valid=0.
- hazard_nop=1 for 3 cycles while head pc=0x8000_0004 -> ifu_instr/ifu_pc unchanged and instr_valid=0; imem_req drops once outstanding+count=2; normal flow resumes after release.
- flush_nop with 2 outstanding, redirect_pc=0x8000_1002 -> both stale responses discarded; next ifu_pc=0x8000_1000 and next imem_addr=0x8000_1000; no imem_req in the flush cycle.
- flush_nop and hazard_nop in the same cycle, with rvalid in that same cycle -> flush wins, queue empties, arriving response dropped, drop_cnt correct (no stray instruction later).
- Assert rst mid-stream with a full queue -> all outputs return to reset values asynchronously; fetching restarts at 0x8000_0000 after release.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues word fetches and queues returned instructions.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_nop,
  input  logic [63:0] redirect_pc,
  input  logic        hazard_nop,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifu_instr,
  output logic [63:0] ifu_pc,
  output logic [63:0] ifu_snxt_pc,
  output logic        ifu_valid,
`ifdef IFU_PERF_CNT_EN
  output logic        instr_valid,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt
`else
  output logic        instr_valid
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [63:0]   r_fetch_pc;
  logic [63:0]   r_deq_pc;
  logic [31:0]   r_q [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;

  logic [CW:0]   w_sum;
  logic          w_cap_ok;
  logic          w_grant;
  logic          w_pop;
  logic          w_push;
  logic          w_discard;
  logic [63:0]   w_redir;

  // Outstanding fetches include those still to be dropped, so this one cap covers both cases.
  assign w_sum     = {1'b0, r_outst} + {1'b0, r_count};
  assign w_cap_ok  = w_sum < (CW+1)'(DEPTH);
  assign imem_req  = ~rst & ~flush_nop & w_cap_ok;
  assign imem_addr = r_fetch_pc;

  assign ifu_valid   = (r_count != '0);
  assign ifu_instr   = r_q[r_rd_ptr];
  assign ifu_pc      = r_deq_pc;
  assign ifu_snxt_pc = r_deq_pc + 64'd4;
  assign instr_valid = ifu_valid & ~hazard_nop & ~flush_nop;

  assign w_grant   = imem_req & imem_gnt;
  assign w_pop     = instr_valid;
  assign w_push    = imem_rvalid & ~flush_nop & (r_drop == '0);
  assign w_discard = imem_rvalid & ~flush_nop & (r_drop != '0);
  assign w_redir   = redirect_pc & ~64'h3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_deq_pc   <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_drop     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_q[i] <= '0;
      end
    end else if (flush_nop) begin
      // No grant can occur here; a response arriving this cycle is consumed by the flush.
      r_fetch_pc <= w_redir;
      r_deq_pc   <= w_redir;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_outst    <= r_outst - CW'(imem_rvalid);
      r_drop     <= r_outst - CW'(imem_rvalid);
    end else begin
      if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + 64'd4;
      end
      if (w_pop) begin
        r_deq_pc <= r_deq_pc + 64'd4;
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        r_q[r_wr_ptr] <= imem_rdata;
        r_wr_ptr      <= r_wr_ptr + PW'(1);
      end
      if (w_discard) begin
        r_drop <= r_drop - CW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_outst <= r_outst + CW'(w_grant) - CW'(imem_rvalid);
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [63:0] r_perf_fetch;
  logic [63:0] r_perf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (instr_valid) begin
        r_perf_fetch <= r_perf_fetch + 64'd1;
      end
      if (~ifu_valid & ~flush_nop) begin
        r_perf_stall <= r_perf_stall + 64'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed, table-driven bench for ifu_fetch: per-cycle input/expected-output records
// plus a hand-written asynchronous mid-stream reset sequence.
module tb_ifu_fetch;

  localparam logic [63:0] P  = 64'h8000_0000;
  localparam logic [63:0] Q1 = 64'h8000_1000;
  localparam logic [63:0] Q2 = 64'h8000_2000;
  localparam logic [63:0] Q3 = 64'h8000_3000;
  localparam logic [63:0] Q4 = 64'h8000_4000;
  localparam logic [63:0] W  = 64'hFFFF_FFFF_FFFF_FFFC;

  localparam logic [31:0] IA = 32'h0000_0013;
  localparam logic [31:0] IB = 32'h0010_0093;
  localparam logic [31:0] IC = 32'h0020_0113;
  localparam logic [31:0] ID = 32'h0030_0193;
  localparam logic [31:0] IE = 32'h0040_0213;
  localparam logic [31:0] IF = 32'h0050_0293;
  localparam logic [31:0] IG = 32'h0060_0313;
  localparam logic [31:0] IH = 32'h0070_0393;
  localparam logic [31:0] II = 32'h0080_0413;
  localparam logic [31:0] IX = 32'hDEAD_0001;
  localparam logic [31:0] IY = 32'hDEAD_0002;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_nop = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        hazard_nop = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ifu_instr;
  logic [63:0] ifu_pc;
  logic [63:0] ifu_snxt_pc;
  logic        ifu_valid;
  logic        instr_valid;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  ifu_fetch #(
    .RESET_PC(P),
    .DEPTH   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_nop  (flush_nop),
    .redirect_pc(redirect_pc),
    .hazard_nop (hazard_nop),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .ifu_instr  (ifu_instr),
    .ifu_pc     (ifu_pc),
    .ifu_snxt_pc(ifu_snxt_pc),
    .ifu_valid  (ifu_valid),
`ifdef IFU_PERF_CNT_EN
    .instr_valid   (instr_valid),
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`else
    .instr_valid(instr_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic [63:0] rpc;
    logic        hz;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        req;
    logic [63:0] addr;
    logic        v;
    logic [63:0] pc;
    logic        iv;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic r, input logic fl, input logic [63:0] rpc, input logic hz,
                     input logic gnt, input logic rv, input logic [31:0] rdata,
                     input logic req, input logic [63:0] addr, input logic v,
                     input logic [63:0] pc, input logic iv, input logic [31:0] instr);
    vec_t t;
    t.rst = r;   t.fl = fl;     t.rpc = rpc;   t.hz = hz;  t.gnt = gnt; t.rv = rv;
    t.rdata = rdata; t.req = req; t.addr = addr; t.v = v;  t.pc = pc;   t.iv = iv;
    t.instr = instr;
    vecs.push_back(t);
  endtask

  task automatic add_rst();
    add(1, 0, 0, 0, 0, 0, 0, 0, P, 0, P, 0, 0);
  endtask

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic fl, input logic [63:0] rpc, input logic hz,
                       input logic gnt, input logic rv, input logic [31:0] rdata);
    @(negedge clk);
    rst = r; flush_nop = fl; redirect_pc = rpc; hazard_nop = hz;
    imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rdata;
  endtask

  initial begin
    // Main flow, back-to-back grants with 1-cycle response latency
    add_rst();
    add(0, 0, 0, 0, 1, 0, 0,  1, P,      0, P,      0, 0);
    add(0, 0, 0, 0, 1, 1, IA, 1, P + 4,  0, P,      0, 0);
    add(0, 0, 0, 0, 1, 1, IB, 0, P + 8,  1, P,      1, IA);
    add(0, 0, 0, 0, 1, 0, 0,  1, P + 8,  1, P + 4,  1, IB);
    add(0, 0, 0, 0, 1, 1, IC, 1, P + 12, 0, P + 8,  0, 0);
    add(0, 0, 0, 0, 1, 1, ID, 0, P + 16, 1, P + 8,  1, IC);
    add(0, 0, 0, 0, 0, 0, 0,  1, P + 16, 1, P + 12, 1, ID);
    // Grant withheld: request and address held
    add_rst();
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 1, P, 0, P, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  1, P,     0, P, 0, 0);
    add(0, 0, 0, 0, 0, 1, IE, 1, P + 4, 0, P, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, P + 4, 1, P, 1, IE);
    // Hazard holds head at P+4 while the cap throttles requests
    add_rst();
    add(0, 0, 0, 0, 1, 0, 0,  1, P,      0, P,      0, 0);
    add(0, 0, 0, 0, 1, 1, IA, 1, P + 4,  0, P,      0, 0);
    add(0, 0, 0, 0, 1, 1, IB, 0, P + 8,  1, P,      1, IA);
    add(0, 0, 0, 1, 1, 0, 0,  1, P + 8,  1, P + 4,  0, IB);
    add(0, 0, 0, 1, 1, 1, IC, 0, P + 12, 1, P + 4,  0, IB);
    add(0, 0, 0, 1, 1, 0, 0,  0, P + 12, 1, P + 4,  0, IB);
    add(0, 0, 0, 0, 1, 0, 0,  0, P + 12, 1, P + 4,  1, IB);
    add(0, 0, 0, 0, 1, 0, 0,  1, P + 12, 1, P + 8,  1, IC);
    add(0, 0, 0, 0, 0, 1, ID, 1, P + 16, 0, P + 12, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, P + 16, 1, P + 12, 1, ID);
    // Flush with two fetches outstanding; misaligned redirect
    add_rst();
    add(0, 0, 0,            0, 1, 0, 0,  1, P,      0, P,      0, 0);
    add(0, 0, 0,            0, 1, 0, 0,  1, P + 4,  0, P,      0, 0);
    add(0, 1, 64'h8000_1002, 0, 1, 0, 0, 0, P + 8,  0, P,      0, 0);
    add(0, 0, 0,            0, 1, 1, IX, 0, Q1,     0, Q1,     0, 0);
    add(0, 0, 0,            0, 1, 1, IY, 1, Q1,     0, Q1,     0, 0);
    add(0, 0, 0,            0, 0, 1, IF, 1, Q1 + 4, 0, Q1,     0, 0);
    add(0, 0, 0,            0, 0, 0, 0,  1, Q1 + 4, 1, Q1,     1, IF);
    add(0, 0, 0,            0, 0, 0, 0,  1, Q1 + 4, 0, Q1 + 4, 0, 0);
    // Flush + hazard + rvalid together, then redirect to the top of memory and wrap
    add_rst();
    add(0, 0, 0,  0, 1, 0, 0,  1, P,      0, P,      0, 0);
    add(0, 0, 0,  0, 1, 1, IA, 1, P + 4,  0, P,      0, 0);
    add(0, 0, 0,  1, 0, 0, 0,  0, P + 8,  1, P,      0, IA);
    add(0, 1, Q2, 1, 1, 1, IB, 0, P + 8,  1, P,      0, IA);
    add(0, 0, 0,  0, 1, 0, 0,  1, Q2,     0, Q2,     0, 0);
    add(0, 0, 0,  0, 0, 1, IG, 1, Q2 + 4, 0, Q2,     0, 0);
    add(0, 0, 0,  0, 0, 0, 0,  1, Q2 + 4, 1, Q2,     1, IG);
    add(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 0, 0, Q2 + 4, 0, Q2 + 4, 0, 0);
    add(0, 0, 0,  0, 1, 0, 0,  1, W,      0, W,      0, 0);
    add(0, 0, 0,  0, 0, 1, IH, 1, 64'h0,  0, W,      0, 0);
    add(0, 0, 0,  0, 0, 0, 0,  1, 64'h0,  1, W,      1, IH);
    add(0, 0, 0,  0, 0, 0, 0,  1, 64'h0,  0, 64'h0,  0, 0);
    // Back-to-back flushes, second one sees a response arrive
    add_rst();
    add(0, 0, 0,  0, 1, 0, 0,  1, P,      0, P,  0, 0);
    add(0, 0, 0,  0, 1, 0, 0,  1, P + 4,  0, P,  0, 0);
    add(0, 1, Q3, 0, 1, 0, 0,  0, P + 8,  0, P,  0, 0);
    add(0, 1, Q4, 0, 1, 1, IX, 0, Q3,     0, Q3, 0, 0);
    add(0, 0, 0,  0, 0, 1, IY, 1, Q4,     0, Q4, 0, 0);
    add(0, 0, 0,  0, 1, 0, 0,  1, Q4,     0, Q4, 0, 0);
    add(0, 0, 0,  0, 0, 1, II, 1, Q4 + 4, 0, Q4, 0, 0);
    add(0, 0, 0,  0, 0, 0, 0,  1, Q4 + 4, 1, Q4, 1, II);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].rpc, vecs[i].hz, vecs[i].gnt, vecs[i].rv,
            vecs[i].rdata);
      #1;
      chk("imem_req", i, 64'(imem_req), 64'(vecs[i].req));
      chk("imem_addr", i, imem_addr, vecs[i].addr);
      chk("ifu_valid", i, 64'(ifu_valid), 64'(vecs[i].v));
      chk("ifu_pc", i, ifu_pc, vecs[i].pc);
      chk("ifu_snxt_pc", i, ifu_snxt_pc, vecs[i].pc + 64'd4);
      chk("instr_valid", i, 64'(instr_valid), 64'(vecs[i].iv));
      if (vecs[i].v || vecs[i].rst) chk("ifu_instr", i, 64'(ifu_instr), 64'(vecs[i].instr));
    end

    // Fill the queue under hazard, then assert reset asynchronously between edges
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 1, IA);
    drive(0, 0, 0, 1, 1, 1, IB);
    drive(0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("full_valid", 1000, 64'(ifu_valid), 64'd1);
    chk("full_req", 1000, 64'(imem_req), 64'd0);
    chk("full_instr", 1000, 64'(ifu_instr), 64'(IA));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_req", 1001, 64'(imem_req), 64'd0);
    chk("async_addr", 1001, imem_addr, P);
    chk("async_valid", 1001, 64'(ifu_valid), 64'd0);
    chk("async_iv", 1001, 64'(instr_valid), 64'd0);
    chk("async_instr", 1001, 64'(ifu_instr), 64'd0);
    chk("async_pc", 1001, ifu_pc, P);
    chk("async_snxt", 1001, ifu_snxt_pc, P + 64'd4);
    drive(0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("restart_req", 1002, 64'(imem_req), 64'd1);
    chk("restart_addr", 1002, imem_addr, P);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("restart_addr2", 1003, imem_addr, P + 64'd4);
    chk("restart_valid", 1003, 64'(ifu_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
